sr_latch_writer: RTL and testbench

- Synchronous write controller for the gated SR latch storage cell: the writer side of the cell's E/S/R interface.
- Converts a single-bit valid/ready write request into a sequenced, glitch-safe S/R/E pulse train: set-up, enable pulse, hold.
- Forces a known latch state after reset.
- Sits between lab control logic (switch/button FSMs) and one external latch instance. Reports completion, and optionally a read-back check of Q/Qbar.

---
 rtl/sr_latch_writer.sv | 204 ++++++++++++++++++++
 tb/tb_sr_latch_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_writer.sv
// Write sequencer for one gated SR latch: SETUP -> PULSE -> HOLD -> DONE, with an INIT write of 0 after reset.
// Optional read-back verification and retry is built when SR_READBACK_CHECK_EN is defined.
module sr_latch_writer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_val,
    output logic done,
    output logic err,
    output logic stored_val,
    output logic lat_e,
    output logic lat_s,
    output logic lat_r,
    input  logic lat_q,
    input  logic lat_qbar
);
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_ALL = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
`ifdef SR_READBACK_CHECK_EN
        ST_SYNC,
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          val_q;
    logic          init_q;
    logic          ready_q;
    logic          done_q;
    logic          stored_q;
    logic          e_q;
    logic          s_q;
    logic          r_q;

`ifdef SR_READBACK_CHECK_EN
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    logic [RW-1:0] retry_q;
    logic          err_q;
    logic [1:0]    q_sync_q;
    logic [1:0]    qb_sync_q;

    // Latch outputs are asynchronous to clk; two flops before they are compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sync_q  <= '0;
            qb_sync_q <= '0;
        end else begin
            q_sync_q  <= {q_sync_q[0], lat_q};
            qb_sync_q <= {qb_sync_q[0], lat_qbar};
        end
    end

    assign err = err_q;
`else
    logic unused_ok;
    assign unused_ok = ^{lat_q, lat_qbar, (MAX_RETRY > 0)};
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            val_q    <= 1'b0;
            init_q   <= 1'b1;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            stored_q <= 1'b0;
            e_q      <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
`ifdef SR_READBACK_CHECK_EN
            retry_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    val_q   <= 1'b0;
                    init_q  <= 1'b1;
                    s_q     <= 1'b0;
                    r_q     <= 1'b1;
                    cnt_q   <= CW'(SETUP_CYC - 1);
                    state_q <= ST_SETUP;
`ifdef SR_READBACK_CHECK_EN
                    retry_q <= '0;
`endif
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        val_q   <= req_val;
                        init_q  <= 1'b0;
                        s_q     <= req_val;
                        r_q     <= ~req_val;
                        ready_q <= 1'b0;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        state_q <= ST_SETUP;
`ifdef SR_READBACK_CHECK_EN
                        retry_q <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= CW'(PULSE_CYC - 1);
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
`ifdef SR_READBACK_CHECK_EN
                        cnt_q   <= CW'(1);
                        state_q <= ST_SYNC;
`else
                        s_q      <= 1'b0;
                        r_q      <= 1'b0;
                        done_q   <= ~init_q;
                        stored_q <= val_q;
                        state_q  <= ST_DONE;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef SR_READBACK_CHECK_EN
                ST_SYNC: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if ((q_sync_q[1] == val_q) && (qb_sync_q[1] == ~val_q)) begin
                        s_q      <= 1'b0;
                        r_q      <= 1'b0;
                        done_q   <= ~init_q;
                        stored_q <= val_q;
                        err_q    <= 1'b0;
                        state_q  <= ST_DONE;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        // S/R still carry val_q, so the retry re-enters SETUP without touching them.
                        retry_q <= retry_q + 1'b1;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        state_q <= ST_SETUP;
                    end else begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        done_q  <= ~init_q;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    e_q     <= 1'b0;
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign done       = done_q;
    assign stored_val = stored_q;
    assign lat_e      = e_q;
    assign lat_s      = s_q;
    assign lat_r      = r_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Bench for sr_latch_writer: per-cycle waveform vectors, a write scoreboard, and abort/retry sequences.
module tb_sr_latch_writer;
    localparam int PULSE = 4;
`ifdef SR_READBACK_CHECK_EN
    localparam int DONE_K = 11;
`else
    localparam int DONE_K = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic req_ready, done, err, stored_val, lat_e, lat_s, lat_r;
    logic lat_q, lat_qbar;

    // Behavioural gated SR latch, with an optional stuck-at-0 fault on Q.
    logic q_m = 1'b0;
    logic stuck = 1'b0;
    always @(posedge clk) begin
        if (lat_e) begin
            if (lat_s) q_m <= 1'b1;
            else if (lat_r) q_m <= 1'b0;
        end
    end
    assign lat_q    = stuck ? 1'b0 : q_m;
    assign lat_qbar = ~q_m;

    sr_latch_writer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_val(req_val), .done(done), .err(err), .stored_val(stored_val),
        .lat_e(lat_e), .lat_s(lat_s), .lat_r(lat_r), .lat_q(lat_q), .lat_qbar(lat_qbar)
    );

    typedef struct packed {logic val; logic stored; logic err;} sb_t;
    typedef struct {logic val; logic exp_stored;} vec_t;
    sb_t  sb_q[$];
    vec_t vecs[5];

    int   total = 0;
    int   bad = 0;
    logic prev_e = 1'b0, prev_s = 1'b0, prev_r = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // One clock; latch-side invariants are checked on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        total++;
        if (lat_s && lat_r) begin
            bad++;
            $display("FAIL sr_excl: got S=1 R=1 expected not both (t=%0t)", $time);
        end
        if (rst_n && (lat_e || prev_e)) begin
            total++;
            if ({lat_s, lat_r} !== {prev_s, prev_r}) begin
                bad++;
                $display("FAIL sr_stable_e: got SR=%b%b expected %b%b (t=%0t)", lat_s, lat_r, prev_s, prev_r, $time);
            end
        end
        prev_e = lat_e;
        prev_s = lat_s;
        prev_r = lat_r;
    endtask

    task automatic sb_pop();
        sb_t e;
        check("sb_pending", 8'(sb_q.size() != 0), 8'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("stored_val", 8'(stored_val), 8'(e.stored));
            check("err", 8'(err), 8'(e.err));
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60 && !req_ready; i++) tick();
        check("ready_wait", 8'(req_ready), 8'd1);
    endtask

    // Called with the observation for cycle 1 already visible; leaves the bench at cycle DONE_K+1.
    task automatic run_seq(input logic v, input logic init_seq);
        for (int k = 1; k <= DONE_K + 1; k++) begin
            logic [4:0] ex;
            ex[4] = (k >= 2) && (k <= PULSE + 1);
            ex[3] = v && (k <= DONE_K - 1);
            ex[2] = !v && (k <= DONE_K - 1);
            ex[1] = !init_seq && (k == DONE_K);
            ex[0] = (k == DONE_K + 1);
            check($sformatf("%s_k%0d", init_seq ? "init_wave" : "write_wave", k),
                  8'({lat_e, lat_s, lat_r, done, req_ready}), 8'(ex));
            if (!init_seq && k == DONE_K && done) sb_pop();
            if (k <= DONE_K) tick();
        end
    endtask

    task automatic do_write(input logic v, input logic exp_stored, input logic exp_err);
        wait_ready();
        req_valid = 1'b1;
        req_val   = v;
        sb_q.push_back(sb_t'{v, exp_stored, exp_err});
        tick();
        req_valid = 1'b0;
        check("err_at_accept", 8'(err), 8'd0);
        run_seq(v, 1'b0);
    endtask

    initial begin
        int   acc[$];
        logic bvals[3];
        int   idx;
        int   k;
        int   pulses;
        logic pe;

        vecs[0] = '{1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0};

        // Reset, then the INIT write of 0 with no done pulse.
        tick();
        tick();
        check("reset_state", 8'({lat_e, lat_s, lat_r, req_ready, done, err, stored_val}), 8'd0);
        rst_n = 1'b1;
        tick();
        run_seq(1'b0, 1'b1);
        check("init_status", 8'({stored_val, err}), 8'd0);
`ifdef SR_READBACK_CHECK_EN
        check("init_model_q", 8'(q_m), 8'd0);
`endif

        for (int i = 0; i < 5; i++) do_write(vecs[i].val, vecs[i].exp_stored, 1'b0);

        // Back-to-back writes with req_valid held high.
        bvals[0] = 1'b1;
        bvals[1] = 1'b0;
        bvals[2] = 1'b1;
        idx = 0;
        req_valid = 1'b1;
        req_val = bvals[0];
        for (int c = 0; c < 80 && !(idx == 3 && sb_q.size() == 0); c++) begin
            if (req_valid && req_ready) begin
                acc.push_back(c);
                sb_q.push_back(sb_t'{bvals[idx], bvals[idx], 1'b0});
                idx++;
            end
            tick();
            if (done) sb_pop();
            if (idx == 3) req_valid = 1'b0;
            else req_val = bvals[idx];
        end
        req_valid = 1'b0;
        check("b2b_count", 8'(acc.size()), 8'd3);
        if (acc.size() == 3) begin
            check("b2b_gap1", 8'(acc[1] - acc[0]), 8'(DONE_K + 1));
            check("b2b_gap2", 8'(acc[2] - acc[1]), 8'(DONE_K + 1));
        end

        // Reset during PULSE of a write of 1: abort, then INIT restores 0.
        wait_ready();
        req_valid = 1'b1;
        req_val = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("pre_abort_e", 8'(lat_e), 8'd1);
        rst_n = 1'b0;
        tick();
        check("abort_outputs", 8'({lat_e, lat_s, lat_r, done, req_ready}), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_seq(1'b0, 1'b1);
        check("abort_stored", 8'(stored_val), 8'd0);

`ifdef SR_READBACK_CHECK_EN
        check("abort_model_q", 8'(q_m), 8'd0);
        do_write(1'b1, 1'b1, 1'b0);
        check("model_q_after_1", 8'({q_m, lat_qbar}), 8'b10);
        do_write(1'b0, 1'b0, 1'b0);

        // Q stuck at 0: three attempts, then err with stored_val unchanged.
        stuck = 1'b1;
        wait_ready();
        req_valid = 1'b1;
        req_val = 1'b1;
        sb_q.push_back(sb_t'{1'b1, 1'b0, 1'b1});
        tick();
        req_valid = 1'b0;
        k = 1;
        pulses = 0;
        pe = lat_e;
        while (!done && k < 60) begin
            tick();
            k++;
            if (lat_e && !pe) pulses++;
            pe = lat_e;
        end
        check("retry_done_k", 8'(k), 8'(DONE_K + 20));
        check("retry_pulses", 8'(pulses), 8'd3);
        if (done) sb_pop();
        tick();
        stuck = 1'b0;
        check("err_held_idle", 8'(err), 8'd1);
        do_write(1'b1, 1'b1, 1'b0);
`endif

        check("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
